// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush and hold.
// Define ID_EX_SKID_EN to add a skid entry and a registered ready_o.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        reg_wen_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic        reg_wen_o,
    output logic [4:0]  rd_addr_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        flush_i,
    input  logic        hold_i
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        wen;
        logic [4:0]  rd;
    } beat_t;

    beat_t in_beat;
    beat_t main_q, main_d;
    logic  main_vld_q, main_vld_d;
    logic  in_xfer, out_xfer;

    assign in_beat  = '{inst: inst_i, addr: inst_addr_i, op1: op1_i, op2: op2_i,
                        wen: reg_wen_i, rd: rd_addr_i};
    assign valid_o  = main_vld_q & ~hold_i;
    assign in_xfer  = valid_i & ready_o & ~hold_i & ~flush_i;
    assign out_xfer = valid_o & ready_i & ~flush_i;

`ifdef ID_EX_SKID_EN
    beat_t skid_q, skid_d;
    logic  skid_vld_q, skid_vld_d;
    logic  ready_q;

    assign ready_o = ready_q & ~hold_i;

    // ready_o is low whenever skid is full, so a skid->main move never meets an input beat
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_xfer) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_xfer) begin
                main_d     = in_beat;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (main_vld_q) begin
                skid_d     = in_beat;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = in_beat;
                main_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ~skid_vld_d;
        end
    end
`else
    assign ready_o = (~valid_o | ready_i) & ~hold_i;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
        end else if (in_xfer) begin
            main_d     = in_beat;
            main_vld_d = 1'b1;
        end else if (out_xfer) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    // Empty main presents a bubble; reg_wen_o is additionally gated by hold via valid_o
    always_comb begin
        inst_o      = main_vld_q ? main_q.inst : NOP;
        inst_addr_o = main_vld_q ? main_q.addr : '0;
        op1_o       = main_vld_q ? main_q.op1  : '0;
        op2_o       = main_vld_q ? main_q.op2  : '0;
        rd_addr_o   = main_vld_q ? main_q.rd   : '0;
        reg_wen_o   = valid_o & main_q.wen;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, corner sequences and a
// queue-based random scoreboard. Build with or without ID_EX_SKID_EN.
module tb_id_ex_stage;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef ID_EX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_i = '0, inst_addr_i = '0, op1_i = '0, op2_i = '0;
    logic        reg_wen_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        valid_i = 1'b0, ready_i = 1'b0, flush_i = 1'b0, hold_i = 1'b0;
    logic        ready_o, reg_wen_o, valid_o;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .reg_wen_i(reg_wen_i), .rd_addr_i(rd_addr_i), .valid_i(valid_i), .ready_o(ready_o),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .reg_wen_o(reg_wen_o), .rd_addr_o(rd_addr_o), .valid_o(valid_o), .ready_i(ready_i),
        .flush_i(flush_i), .hold_i(hold_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, check outputs at the falling edge, advance past the rising edge
    task automatic step(input logic v, r, h, f, input logic [31:0] inst, input logic [4:0] rd,
                        input logic ev, er, input logic [31:0] einst, input logic [4:0] erd,
                        input logic ewen, input string tag);
        valid_i = v; ready_i = r; hold_i = h; flush_i = f;
        inst_i = inst; rd_addr_i = rd; reg_wen_i = 1'b1;
        inst_addr_i = '0; op1_i = '0; op2_i = '0;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid_o), 32'(ev));
        chk({tag, "_ready"}, 32'(ready_o), 32'(er));
        chk({tag, "_inst"}, inst_o, einst);
        chk({tag, "_rd"}, 32'(rd_addr_o), 32'(erd));
        chk({tag, "_wen"}, 32'(reg_wen_o), 32'(ewen));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v, r, h, f;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic ev, er;
        logic [31:0] einst;
        logic [4:0]  erd;
        logic ewen;
    } step_t;

    typedef struct packed {
        logic [31:0] inst, addr, op1, op2;
        logic        wen;
        logic [4:0]  rd;
    } beat_t;

    localparam logic [31:0] A  = 32'h00500093;
    localparam logic [31:0] B  = 32'h00700113;
    localparam logic [31:0] C  = 32'h00900193;
    localparam logic [31:0] H  = 32'h00a00113;
    localparam logic [31:0] F1 = 32'h00300193;
    localparam logic [31:0] F2 = 32'h00400213;
    localparam logic [31:0] G  = 32'h00600293;

    step_t tbl[15];
    beat_t q[$];
    beat_t cur;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, A,     5'd1, 1'b0, 1'b1, NOP, 5'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,    5'd0, 1'b1, 1'b1, A,   5'd1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,    5'd0, 1'b0, 1'b1, NOP, 5'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, H,     5'd2, 1'b0, 1'b1, NOP, 5'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, '0,    5'd0, 1'b0, 1'b0, H,   5'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, '0,    5'd0, 1'b0, 1'b0, H,   5'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, '0,    5'd0, 1'b0, 1'b0, H,   5'd2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,    5'd0, 1'b1, 1'b1, H,   5'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,    5'd0, 1'b0, 1'b1, NOP, 5'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, F1,    5'd3, 1'b0, 1'b1, NOP, 5'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, F2,    5'd4, 1'b1, 1'b1, F1,  5'd3, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, '0,    5'd0, 1'b0, 1'b1, NOP, 5'd0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, G,     5'd5, 1'b0, 1'b1, NOP, 5'd0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, '0,    5'd0, 1'b0, 1'b0, G,   5'd5, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, '0,    5'd0, 1'b0, 1'b1, NOP, 5'd0, 1'b0};

        // Outputs while in reset
        #12;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_inst", inst_o, NOP);
        chk("rst_wen", 32'(reg_wen_o), 32'd0);
        chk("rst_op1", op1_o, 32'd0);
        chk("rst_addr", inst_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++)
            step(tbl[i].v, tbl[i].r, tbl[i].h, tbl[i].f, tbl[i].inst, tbl[i].rd,
                 tbl[i].ev, tbl[i].er, tbl[i].einst, tbl[i].erd, tbl[i].ewen,
                 $sformatf("tbl%0d", i));

        // Two beats against a stalled consumer, then drained in order
        step(1, 0, 0, 0, A, 5'd1, 0, 1, NOP, 5'd0, 0, "bp0");
        step(1, 0, 0, 0, B, 5'd2, 1, SKID, A, 5'd1, 1, "bp1");
        step(!SKID, 0, 0, 0, B, 5'd2, 1, 0, A, 5'd1, 1, "bp2");
        step(!SKID, 1, 0, 0, B, 5'd2, 1, !SKID, A, 5'd1, 1, "bp3");
        step(0, 1, 0, 0, '0, 5'd0, 1, 1, B, 5'd2, 1, "bp4");
        step(0, 1, 0, 0, '0, 5'd0, 0, 1, NOP, 5'd0, 0, "bp5");

        // Flush with stored entries and an incoming beat C
        step(1, 0, 0, 0, A, 5'd1, 0, 1, NOP, 5'd0, 0, "fl0");
        step(1, 0, 0, 0, B, 5'd2, 1, SKID, A, 5'd1, 1, "fl1");
        step(1, 0, 0, 1, C, 5'd3, 1, 0, A, 5'd1, 1, "fl2");
        step(0, 1, 0, 0, '0, 5'd0, 0, 1, NOP, 5'd0, 0, "fl3");
        step(0, 1, 0, 0, '0, 5'd0, 0, 1, NOP, 5'd0, 0, "fl4");

        // Asynchronous reset between edges with stored entries
        step(1, 0, 0, 0, A, 5'd1, 0, 1, NOP, 5'd0, 0, "ar0");
        step(1, 0, 0, 0, B, 5'd2, 1, SKID, A, 5'd1, 1, "ar1");
        valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 32'(valid_o), 32'd0);
        chk("ar_inst", inst_o, NOP);
        chk("ar_ready", 32'(ready_o), 32'd1);
        chk("ar_wen", 32'(reg_wen_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(0, 1, 0, 0, '0, 5'd0, 0, 1, NOP, 5'd0, 0, "ar2");
        step(0, 1, 0, 0, '0, 5'd0, 0, 1, NOP, 5'd0, 0, "ar3");

        // Random traffic against a FIFO-queue reference model
        q.delete();
        for (int n = 0; n < 1000; n++) begin
            logic ev, er, in_x, out_x;
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 6);
            hold_i  = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 19) == 0);
            inst_i = $urandom; inst_addr_i = $urandom; op1_i = $urandom; op2_i = $urandom;
            reg_wen_i = 1'($urandom); rd_addr_i = 5'($urandom);
            cur = '{inst: inst_i, addr: inst_addr_i, op1: op1_i, op2: op2_i,
                    wen: reg_wen_i, rd: rd_addr_i};
            ev = (q.size() > 0) && !hold_i;
            er = SKID ? ((q.size() < 2) && !hold_i) : ((!ev || ready_i) && !hold_i);
            @(negedge clk);
            chk("rnd_valid", 32'(valid_o), 32'(ev));
            chk("rnd_ready", 32'(ready_o), 32'(er));
            if (q.size() > 0) begin
                chk("rnd_inst", inst_o, q[0].inst);
                chk("rnd_addr", inst_addr_o, q[0].addr);
                chk("rnd_op1", op1_o, q[0].op1);
                chk("rnd_op2", op2_o, q[0].op2);
                chk("rnd_rd", 32'(rd_addr_o), 32'(q[0].rd));
                chk("rnd_wen", 32'(reg_wen_o), 32'(ev & q[0].wen));
            end else begin
                chk("rnd_bubble_inst", inst_o, NOP);
                chk("rnd_bubble_wen", 32'(reg_wen_o), 32'd0);
                chk("rnd_bubble_op1", op1_o, 32'd0);
            end
            in_x  = valid_i && er && !hold_i && !flush_i;
            out_x = ev && ready_i && !flush_i;
            @(posedge clk);
            if (flush_i) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) q.push_back(cur);
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have rst, input, 1, reset that is asynchronous and active-low.
REQ-003 The block SHALL have inst_i, input, 32, decoded instruction word from id.
REQ-004 The block SHALL have inst_addr_i, input, 32, PC of inst_i.
REQ-005 The block SHALL have op1_i and op2_i, input, 32 each, operands from id.
REQ-006 The block SHALL have reg_wen_i, input, 1, register write enable from id.
REQ-007 The block SHALL have rd_addr_i, input, 5, destination register from id.
REQ-008 The block SHALL have valid_i, input, 1, id beat valid.
REQ-009 The block SHALL have ready_o, output, 1, stage can accept a beat.
REQ-010 The block SHALL have inst_o, inst_addr_o, op1_o, op2_o (32 each), reg_wen_o (1) and rd_addr_o (5), all outputs, the payload presented to ex.
REQ-011 The block SHALL have valid_o, output, 1, payload valid to ex.
REQ-012 The block SHALL have ready_i, input, 1, ex consumes the beat.
REQ-013 The block SHALL have flush_i, input, 1, jump_en from ex via ctrl, which kills in-flight beats.
REQ-014 The block SHALL have hold_i, input, 1, hold_flag from ctrl, which freezes the stage.

Function
REQ-015 Input transfer SHALL occur on an edge where valid_i=1, ready_o=1, hold_i=0 and flush_i=0.
REQ-016 Output transfer SHALL occur on an edge where valid_o=1 and ready_i=1.
REQ-017 Storage SHALL consist of a main register and a skid register; occupancy SHALL be 0..2 entries.
REQ-018 ready_o SHALL be driven directly from a flop and SHALL be 1 if and only if the skid register is empty and hold_i=0.
REQ-019 Payload outputs SHALL always come from the main register, giving 1-cycle latency from input transfer to valid_o=1 when the stage was empty.
REQ-020 On an input transfer with no output transfer: if main is empty, the beat SHALL load main; if main is full, it SHALL load skid.
REQ-021 On an output transfer: skid, if full, SHALL move to main; otherwise main SHALL load the simultaneous input beat, or become empty.
REQ-022 Beats SHALL leave in arrival order, with no loss and no duplication.
REQ-023 When hold_i=1, valid_o SHALL be 0, and stored entries SHALL remain unchanged.
REQ-024 When flush_i=1 on an edge, both entries SHALL be invalidated and any incoming beat discarded; flush_i SHALL take priority over hold_i and over all transfers.
REQ-025 When main is empty, outputs SHALL be a bubble: inst_o=32'h00000013 (NOP), reg_wen_o=0, and all other payload outputs 0.
REQ-026 valid_o SHALL never be 1 without stored data, and reg_wen_o SHALL be 0 whenever valid_o=0.

Reset
REQ-027 While rst=0, regardless of clk: both entries SHALL be empty, valid_o=0, ready_o=1 (with hold_i=0), inst_o=NOP, and the remaining payload outputs 0.
REQ-028 Reset asserted mid-transfer SHALL discard all entries, and no beat SHALL reach ex after rst releases until a new input transfer occurs.

Configuration
REQ-029 With ID_EX_SKID_EN defined, the skid register and registered ready_o SHALL be built as above.
REQ-030 Without ID_EX_SKID_EN, the skid register SHALL be omitted, and ready_o SHALL be combinational: ready_o = (!valid_o | ready_i) & !hold_i; all other rules SHALL remain unchanged.

Verification
REQ-031 A bench SHALL cover: reset release, then inst_i=32'h00500093 (addi x1,x0,5) with valid_i=1 and ready_i=1 -> next cycle valid_o=1, inst_o=32'h00500093, rd_addr_o=1.
REQ-032 A bench SHALL cover: ready_i=0 with 2 beats (A, B) sent -> ready_o=0 after B; then ready_i=1 -> A then B on consecutive cycles, no loss.
REQ-033 A bench SHALL cover: 2 entries stored, flush_i=1 with valid_i=1 (C) -> next cycle valid_o=0, inst_o=NOP, and C is never output.
REQ-034 A bench SHALL cover: hold_i=1 for 3 cycles with 1 entry stored -> valid_o=0 and ready_o=0 throughout; the entry is released unchanged after hold_i drops.
REQ-035 A bench SHALL cover: rst=0 asserted between clock edges with 2 entries stored -> valid_o=0 immediately and inst_o=NOP.
REQ-036 A bench SHALL cover: 1000 random valid_i/ready_i/hold_i/flush_i cycles, run with and without ID_EX_SKID_EN -> scoreboard order matches, and no beat survives a flush.
